event_ctl_capture: RTL and testbench

Receiving end for the xPart/yPart event-control outputs.
- Synchronises both lines into the clk domain and detects every change on either line.
- Each change becomes a timestamped event record, buffered in a small FIFO and drained through a valid/ready stream.
- Sits downstream of the event-control logic; feeds the debug/trace collector.

---
 rtl/event_ctl_pkg.sv | 26 ++
 rtl/event_ctl_fifo.sv | 80 ++++++++
 rtl/event_ctl_capture.sv | 134 +++++++++++++
 tb/tb_event_ctl_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_ctl_pkg.sv
// Shared types and constants for the event-control capture path and its consumers.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Record layout, LSB first: y_chg, x_chg, y_new, x_new, then the timestamp field.
package event_ctl_pkg;

   localparam int TS_W       = 16;
   localparam int DROP_CNT_W = 8;

   // Bit offsets inside a packed event record.
   localparam int Y_CHG_BIT = 0;
   localparam int X_CHG_BIT = 1;
   localparam int Y_NEW_BIT = 2;
   localparam int X_NEW_BIT = 3;
   localparam int TS_LSB    = 4;

   typedef struct packed {
      logic [TS_W-1:0] ts;
      logic            x_new;
      logic            y_new;
      logic            x_chg;
      logic            y_chg;
   } evt_rec_t;

endpackage

// File: rtl/event_ctl_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Latency: a push into an empty FIFO is visible on data_o the following cycle.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle; the caller decides what a refused push means.
//
// Ports: clk/rst (sync, active-high); push_i/data_i write side; pop_i read side (ignored when empty);
//        data_o head record (zero while empty); count_o occupancy; full_o/empty_o status.
module event_ctl_fifo
   import event_ctl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   // Head is forced to zero while empty so the output is clean out of reset.
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i & ~empty_o;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push_i & (~full_o | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/event_ctl_capture.sv
// Captures every change on the async xPart/yPart lines as a timestamped record and streams it out.
// Latency: pin change to evt_valid_o is SYNC_STAGES+2 cycles (sync, compare, FIFO write) with an empty FIFO.
// Backpressure: evt_ready_i stalls the head; records arriving at a full FIFO are dropped and counted.
//
// Ports: clk/rst (sync, active-high); x_part_i/y_part_i async lines; enable_i capture enable;
//        evt_valid_o/evt_ready_i/evt_data_o record stream; count_o occupancy;
//        overflow_o/drop_cnt_o drop status, cleared by clr_ovf_i.
module event_ctl_capture #(
   parameter int TS_W        = 16,
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     x_part_i,
   input  logic                     y_part_i,
   input  logic                     enable_i,
   output logic                     evt_valid_o,
   input  logic                     evt_ready_i,
   output logic [TS_W+3:0]          evt_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic [7:0]               drop_cnt_o,
   input  logic                     clr_ovf_i
);

   import event_ctl_pkg::*;

   localparam int              PRIME_W    = 3;
   localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] x_sync_q, x_sync_d;
   logic [SYNC_STAGES-1:0] y_sync_q, y_sync_d;
   logic                   x_b_q, x_b_d;
   logic                   y_b_q, y_b_d;
   logic [PRIME_W-1:0]     prime_cnt_q, prime_cnt_d;
   logic [TS_W-1:0]        ts_q, ts_d;
   logic                   rec_vld_q, rec_vld_d;
   logic [TS_W+3:0]        rec_q, rec_d;
   logic                   ovf_q, ovf_d;
   logic [DROP_CNT_W-1:0]  drop_q, drop_d;

   logic x_s, y_s, x_chg, y_chg, primed;
   logic pop, drop, fifo_full, fifo_empty;

   always_comb begin
      x_sync_d = {x_sync_q[SYNC_STAGES-2:0], x_part_i};
      y_sync_d = {y_sync_q[SYNC_STAGES-2:0], y_part_i};
      x_s      = x_sync_q[SYNC_STAGES-1];
      y_s      = y_sync_q[SYNC_STAGES-1];

      // The synchroniser restarts from zero on reset, so change detection waits until
      // the chain holds post-reset samples and the baseline has captured one of them.
      // Otherwise a line already high at reset release would look like a change.
      primed      = (prime_cnt_q == PRIME_DONE);
      prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);

      x_b_d = x_s;
      y_b_d = y_s;
      x_chg = x_s ^ x_b_q;
      y_chg = y_s ^ y_b_q;
      ts_d  = ts_q + TS_W'(1);

      // Record is built in the detect cycle and written into the FIFO on the next one.
      rec_vld_d                 = (x_chg | y_chg) & enable_i & primed;
      rec_d                     = '0;
      rec_d[TS_LSB +: TS_W]     = ts_q;
      rec_d[X_NEW_BIT]          = x_s;
      rec_d[Y_NEW_BIT]          = y_s;
      rec_d[X_CHG_BIT]          = x_chg;
      rec_d[Y_CHG_BIT]          = y_chg;

      pop  = evt_valid_o & evt_ready_i;
      drop = rec_vld_q & fifo_full & ~pop;

      // A clear coinciding with a drop leaves exactly that one drop recorded.
      if (clr_ovf_i) begin
         ovf_d  = drop;
         drop_d = DROP_CNT_W'(drop);
      end else begin
         ovf_d  = ovf_q | drop;
         drop_d = drop_q;
         if (drop && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + DROP_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_sync_q    <= '0;
         y_sync_q    <= '0;
         x_b_q       <= 1'b0;
         y_b_q       <= 1'b0;
         prime_cnt_q <= '0;
         ts_q        <= '0;
         rec_vld_q   <= 1'b0;
         rec_q       <= '0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
      end else begin
         x_sync_q    <= x_sync_d;
         y_sync_q    <= y_sync_d;
         x_b_q       <= x_b_d;
         y_b_q       <= y_b_d;
         prime_cnt_q <= prime_cnt_d;
         ts_q        <= ts_d;
         rec_vld_q   <= rec_vld_d;
         rec_q       <= rec_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
      end
   end

   event_ctl_fifo #(
      .WIDTH (TS_W + 4),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rec_vld_q),
      .data_i  (rec_q),
      .pop_i   (evt_ready_i),
      .data_o  (evt_data_o),
      .count_o (count_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign evt_valid_o = ~fifo_empty;
   assign overflow_o  = ovf_q;
   assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_event_ctl_capture.sv
// Randomised scoreboard bench for event_ctl_capture.
// Stimulus predicts each record from line levels and the cycle count; a negedge monitor pops and compares.
// Directed phases cover reset, latency, simultaneous change, overflow, clear, enable and mid-run reset.
module tb_event_ctl_capture;
   import event_ctl_pkg::*;

   localparam int TSW   = 16;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_part_i, y_part_i, enable_i, evt_ready_i, clr_ovf_i;
   logic        evt_valid_o;
   logic [TSW+3:0] evt_data_o;
   logic [3:0]  count_o;
   logic        overflow_o;
   logic [7:0]  drop_cnt_o;

   event_ctl_capture #(.TS_W(TSW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .x_part_i(x_part_i), .y_part_i(y_part_i), .enable_i(enable_i),
      .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
      .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clr_ovf_i(clr_ovf_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [TSW+3:0] sb[$];
   bit x_lvl, y_lvl, en_m, rnd_rdy;

   // Cycles since reset release: the timestamp a record should carry.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [TSW+3:0] mk_rec(input logic [TSW-1:0] ts, input bit xn, input bit yn,
                                             input bit xc, input bit yc);
      evt_rec_t r;
      r.ts = ts; r.x_new = xn; r.y_new = yn; r.x_chg = xc; r.y_chg = yc;
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rnd_rdy) evt_ready_i = ($urandom_range(3) != 0);
      end
   endtask

   // Called just after a rising edge. A change seen by the synchroniser at the next edge
   // is compared SYNC cycles later, so its timestamp is the current cycle plus SYNC.
   task automatic toggle(input bit tx, input bit ty, input bit keep);
      x_lvl ^= tx;
      y_lvl ^= ty;
      x_part_i = x_lvl;
      y_part_i = y_lvl;
      if (en_m && keep) sb.push_back(mk_rec(TSW'(cyc + SYNC), x_lvl, y_lvl, tx, ty));
   endtask

   task automatic drain();
      int t;
      evt_ready_i = 1'b1;
      step(SYNC + 3);
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         step(1);
         t++;
      end
      chk("drain_left", sb.size(), 0);
      chk("drain_count", count_o, 0);
   endtask

   task automatic clear_ovf();
      clr_ovf_i = 1'b1;
      step(1);
      clr_ovf_i = 1'b0;
   endtask

   // Monitor: every accepted record must match the next prediction; a stalled head must hold.
   initial begin
      logic [TSW+3:0] exp_rec, stall_dat;
      bit stall_prev;
      stall_prev = 1'b0;
      stall_dat  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && evt_valid_o) chk("stall_stable", evt_data_o, stall_dat);
            if (evt_valid_o && evt_ready_i) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_record: got %0h expected none", evt_data_o);
               end else begin
                  exp_rec = sb.pop_front();
                  chk("record", evt_data_o, exp_rec);
               end
            end
            stall_prev = evt_valid_o && !evt_ready_i;
            stall_dat  = evt_data_o;
         end
      end
   end

   initial begin
      int seen, lat;
      rst = 1'b1; x_part_i = 1'b1; y_part_i = 1'b1; enable_i = 1'b1;
      evt_ready_i = 1'b1; clr_ovf_i = 1'b0; rnd_rdy = 1'b0;
      x_lvl = 1'b1; y_lvl = 1'b1; en_m = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", evt_valid_o, 0);
      chk("rst_data", evt_data_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_drop", drop_cnt_o, 0);

      // Lines held high through reset release must never produce a record.
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         step(1);
         if (evt_valid_o) seen++;
      end
      chk("no_rec_after_reset", seen, 0);
      chk("count_after_reset", count_o, 0);

      // Bring both lines low, then measure a single x rise.
      toggle(0, 1, 1); step(6);
      toggle(1, 0, 1);
      drain();
      toggle(1, 0, 1);
      lat = 0;
      while (!evt_valid_o && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, SYNC + 2);
      step(3);

      // Both lines in the same cycle: a single record.
      evt_ready_i = 1'b0;
      toggle(1, 1, 1);
      step(SYNC + 3);
      chk("both_count", count_o, 1);
      drain();

      // Ten changes with the consumer stalled: eight kept, two dropped.
      evt_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         toggle(1, 0, i < DEPTH);
         step(2);
      end
      step(SYNC + 3);
      chk("ovf_count", count_o, DEPTH);
      chk("ovf_flag", overflow_o, 1);
      chk("ovf_drops", drop_cnt_o, 2);
      drain();
      chk("ovf_sticky", overflow_o, 1);
      clear_ovf();
      chk("clr_flag", overflow_o, 0);
      chk("clr_drops", drop_cnt_o, 0);

      // Full FIFO: push and pop land on the same edge.
      evt_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         toggle(0, 1, 1);
         step(2);
      end
      step(SYNC + 3);
      chk("full_count", count_o, DEPTH);
      toggle(1, 0, 1);
      step(SYNC + 1);
      evt_ready_i = 1'b1;
      step(1);
      evt_ready_i = 1'b0;
      chk("pushpop_count", count_o, DEPTH);
      chk("pushpop_drops", drop_cnt_o, 0);
      chk("pushpop_ovf", overflow_o, 0);

      // Clear coinciding with a drop: exactly one drop remains.
      toggle(1, 0, 0);
      step(SYNC + 3);
      chk("drop1_cnt", drop_cnt_o, 1);
      toggle(1, 0, 0);
      step(SYNC + 1);
      clr_ovf_i = 1'b1;
      step(1);
      clr_ovf_i = 1'b0;
      chk("clrdrop_flag", overflow_o, 1);
      chk("clrdrop_cnt", drop_cnt_o, 1);
      drain();
      clear_ovf();

      // Enable low: queued records still drain, toggles leave nothing, no replay.
      evt_ready_i = 1'b0;
      toggle(0, 1, 1); step(3);
      toggle(1, 0, 1);
      step(SYNC + 3);
      chk("en_queued", count_o, 2);
      enable_i = 1'b0; en_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         toggle(1, 0, 1);
         step(2);
      end
      step(SYNC + 3);
      chk("en_off_count", count_o, 2);
      drain();
      enable_i = 1'b1; en_m = 1'b1;
      step(SYNC + 3);
      chk("en_no_replay", count_o, 0);
      toggle(0, 1, 1);
      drain();

      // Reset with records queued discards them and re-primes.
      evt_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toggle(i[0], ~i[0], 1);
         step(2);
      end
      step(SYNC + 3);
      chk("pre_rst_count", count_o, 4);
      rst = 1'b1;
      step(1);
      chk("mid_rst_count", count_o, 0);
      chk("mid_rst_valid", evt_valid_o, 0);
      sb.delete();
      rst = 1'b0;
      step(SYNC + 4);
      chk("post_rst_count", count_o, 0);
      toggle(1, 0, 1);
      drain();

      // Random traffic with a randomly stalling consumer.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(2))
            0:       toggle(1, 0, 1);
            1:       toggle(0, 1, 1);
            default: toggle(1, 1, 1);
         endcase
         step($urandom_range(6, 3));
      end
      rnd_rdy = 1'b0;
      drain();
      chk("rand_no_ovf", overflow_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
